// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch-stage PC register with sequential increment, stalled-redirect buffering and misaligned-target trap.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_F,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   output logic [31:0] pcout_F,
   output logic [31:0] pc4_F,
   output logic        pend_F,
   output logic        adel_F,
   output logic [31:0] fetch_cnt
);
   localparam logic [1:0] RUN  = 2'b00;
   localparam logic [1:0] PEND = 2'b01;
   localparam logic [1:0] TRAP = 2'b10;
   logic [1:0]  state, state_nxt;
   logic [31:0] pend_tgt, tgt, pc_nxt;
   logic        live, take, bad, load, latch;
   // A fresh redirect in the same cycle beats the buffered one.
   always_comb begin
      live      = state != TRAP;
      tgt       = (state == PEND && !redir_valid) ? pend_tgt : redir_target;
      take      = live && (redir_valid || (state == PEND && !stall_F));
      bad       = take && tgt[1:0] != 2'b00;
      load      = live && !stall_F && !bad;
      latch     = live && stall_F && redir_valid && !bad;
      pc_nxt    = (redir_valid || state == PEND) ? tgt : pc4_F;
      state_nxt = (bad || !live) ? TRAP : load ? RUN : latch ? PEND : state;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         pcout_F   <= RESET_PC;
         pend_tgt  <= '0;
         fetch_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            pcout_F   <= pc_nxt;
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (latch) pend_tgt <= redir_target;
         else if (load) pend_tgt <= '0;
      end
   end
   assign pc4_F  = pcout_F + 32'd4;
   assign pend_F = state == PEND;
   assign adel_F = state == TRAP;
endmodule
